// File: rtl/cb_branch_ctrl_if.sv
// rtl/cb_branch_ctrl_if.sv - handshake bundle between a branch stage controller and its neighbours
interface cb_branch_ctrl_if;
    logic CB_Send_in;
    logic BR;
    logic CB_Ack_in_a;
    logic CB_Ack_in_b;
    logic CB_Ack_out;
    logic CB_Send_out_a;
    logic CB_Send_out_b;
    logic CB_CP;

    modport slave (
        input  CB_Send_in,
        input  BR,
        input  CB_Ack_in_a,
        input  CB_Ack_in_b,
        output CB_Ack_out,
        output CB_Send_out_a,
        output CB_Send_out_b,
        output CB_CP
    );

    modport master (
        output CB_Send_in,
        output BR,
        output CB_Ack_in_a,
        output CB_Ack_in_b,
        input  CB_Ack_out,
        input  CB_Send_out_a,
        input  CB_Send_out_b,
        input  CB_CP
    );
endinterface

// File: rtl/cb_branch_ctrl.sv
// rtl/cb_branch_ctrl.sv - single-token branch stage transfer controller, 4-phase in, 4-phase out on branch a or b
module cb_branch_ctrl #(
    parameter int unsigned DELAY = 1
) (
    input  logic               CLK,
    input  logic               MR,
    cb_branch_ctrl_if.slave    bus
);

    localparam logic [3:0] DELAY_L = 4'(DELAY);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       ack_out_q, ack_out_d;
    logic       send_a_q, send_a_d;
    logic       send_b_q, send_b_d;
    logic       cp_q, cp_d;

    logic       own_ack;
    logic       own_send_q;

    // Only the acknowledge of the branch the token was routed to is ever looked at.
    assign own_ack    = sel_q ? bus.CB_Ack_in_b : bus.CB_Ack_in_a;
    assign own_send_q = sel_q ? send_b_q : send_a_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        ack_out_d = ack_out_q;
        send_a_d  = send_a_q;
        send_b_d  = send_b_q;
        cp_d      = 1'b0;

        // Upstream release is independent of where the token is downstream.
        if (ack_out_q && !bus.CB_Send_in) begin
            ack_out_d = 1'b0;
        end

        case (state_q)
            ST_EMPTY: begin
                if (!ack_out_q && bus.CB_Send_in) begin
                    cp_d      = 1'b1;
                    ack_out_d = 1'b1;
                    sel_d     = bus.BR;
                    cnt_d     = DELAY_L;
                    state_d   = ST_FULL;
                    if (DELAY_L == 4'd0) begin
                        send_a_d = !bus.BR;
                        send_b_d = bus.BR;
                    end
                end
            end
            ST_FULL: begin
                if (!own_send_q) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d    = 4'd0;
                        send_a_d = !sel_q;
                        send_b_d = sel_q;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (own_ack) begin
                    send_a_d = 1'b0;
                    send_b_d = 1'b0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!own_ack) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d  = ST_EMPTY;
                send_a_d = 1'b0;
                send_b_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            state_q   <= ST_EMPTY;
            cnt_q     <= 4'd0;
            sel_q     <= 1'b0;
            ack_out_q <= 1'b0;
            send_a_q  <= 1'b0;
            send_b_q  <= 1'b0;
            cp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            ack_out_q <= ack_out_d;
            send_a_q  <= send_a_d;
            send_b_q  <= send_b_d;
            cp_q      <= cp_d;
        end
    end

    assign bus.CB_Ack_out    = ack_out_q;
    assign bus.CB_Send_out_a = send_a_q;
    assign bus.CB_Send_out_b = send_b_q;
    assign bus.CB_CP         = cp_q;

endmodule

// File: tb/tb_cb_branch_ctrl.sv
// tb/tb_cb_branch_ctrl.sv - randomized bench for cb_branch_ctrl at DELAY 0, 1 and 3 against a timestamp model
module tb_cb_branch_ctrl;

    localparam int NI     = 3;
    localparam int NCYCLE = 2400;

    logic clk;
    logic mr;
    logic send_in;
    logic br;
    logic ack_a [NI];
    logic ack_b [NI];
    logic o_ack [NI];
    logic o_sa  [NI];
    logic o_sb  [NI];
    logic o_cp  [NI];

    int n_checks;
    int n_pass;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            cb_branch_ctrl_if bus ();
            cb_branch_ctrl #(.DELAY((g == 0) ? 0 : ((g == 1) ? 1 : 3))) u_dut (
                .CLK (clk),
                .MR  (mr),
                .bus (bus.slave)
            );
            assign bus.CB_Send_in  = send_in;
            assign bus.BR          = br;
            assign bus.CB_Ack_in_a = ack_a[g];
            assign bus.CB_Ack_in_b = ack_b[g];
            assign o_ack[g]        = bus.CB_Ack_out;
            assign o_sa[g]         = bus.CB_Send_out_a;
            assign o_sb[g]         = bus.CB_Send_out_b;
            assign o_cp[g]         = bus.CB_CP;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dly_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[d%0d] t=%0t got=%b want=%b", tag, dly_of(idx), $time, obs, exp);
        end
    endtask

    // Reference: a token is described by when it was accepted, where it goes and whether its ack came back.
    bit m_have [NI];
    bit m_done [NI];
    bit m_br   [NI];
    int t_acc  [NI];
    bit e_ack  [NI];
    bit e_cp   [NI];
    bit e_sa   [NI];
    bit e_sb   [NI];

    task automatic model_edge(input int cyc);
        for (int i = 0; i < NI; i++) begin
            if (mr) begin
                m_have[i] = 0; m_done[i] = 0; m_br[i] = 0;
                e_ack[i] = 0; e_cp[i] = 0; e_sa[i] = 0; e_sb[i] = 0;
            end else begin
                bit old_ack;
                bit own;
                old_ack  = e_ack[i];
                e_cp[i]  = 0;
                if (old_ack && !send_in) e_ack[i] = 0;
                if (m_have[i]) begin
                    own = m_br[i] ? ack_b[i] : ack_a[i];
                    if (!m_done[i] && (e_sa[i] || e_sb[i]) && own) m_done[i] = 1;
                    else if (m_done[i] && !own) m_have[i] = 0;
                end else if (!old_ack && send_in) begin
                    m_have[i] = 1; m_done[i] = 0; m_br[i] = br;
                    t_acc[i]  = cyc; e_cp[i] = 1; e_ack[i] = 1;
                end
                e_sa[i] = m_have[i] && !m_done[i] && !m_br[i] && (cyc >= t_acc[i] + dly_of(i));
                e_sb[i] = m_have[i] && !m_done[i] &&  m_br[i] && (cyc >= t_acc[i] + dly_of(i));
            end
        end
    endtask

    task automatic drive(input int cyc);
        bit reactive;
        reactive = ((cyc / 300) % 2) == 1;
        if (cyc < 2) begin
            mr = 1'b1; send_in = 1'b1; br = 1'b0;
        end else if (cyc < 3) begin
            mr = 1'b0; send_in = 1'b1;
        end else begin
            mr = ($urandom_range(0, 149) == 0);
            if (cyc >= 1200 && cyc < 1500) send_in = 1'b1;
            else if ($urandom_range(0, 3) == 0) send_in = !send_in;
            br = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < NI; i++) begin
            if (cyc < 3) begin
                ack_a[i] = 1'b0; ack_b[i] = 1'b0;
            end else if (reactive) begin
                if ($urandom_range(0, 2) != 0) begin
                    ack_a[i] = o_sa[i];
                    ack_b[i] = o_sb[i];
                end
            end else begin
                ack_a[i] = 1'($urandom_range(0, 1));
                ack_b[i] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mr = 1'b1; send_in = 1'b1; br = 1'b0;
        for (int i = 0; i < NI; i++) begin
            ack_a[i] = 1'b0; ack_b[i] = 1'b0;
            m_have[i] = 0; m_done[i] = 0; m_br[i] = 0; t_acc[i] = 0;
            e_ack[i] = 0; e_cp[i] = 0; e_sa[i] = 0; e_sb[i] = 0;
        end
        for (int cyc = 0; cyc < NCYCLE; cyc++) begin
            drive(cyc);
            @(posedge clk);
            model_edge(cyc);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("cp",   i, o_cp[i],  e_cp[i]);
                chk("ack",  i, o_ack[i], e_ack[i]);
                chk("sa",   i, o_sa[i],  e_sa[i]);
                chk("sb",   i, o_sb[i],  e_sb[i]);
                chk("excl", i, o_sa[i] & o_sb[i], 1'b0);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cb_branch_ctrl.md
Name: cb_branch_ctrl

Overview:
- Synchronous transfer-control element for one branch stage of the data-driven pipeline.
- Accepts one token from the upstream stage over a 4-phase Send/Ack handshake and emits a one-cycle latch pulse (CB_CP) so the stage captures the packet.
- Forwards the token downstream on branch a or branch b, selected by the packet's branch bit BR.
- Holds at most one token at a time.

Parameters:
- DELAY, 1, clock cycles from the capture edge to assertion of the selected Send_out (models the stage delay element). Legal range 0..15.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- MR  input  1  master reset; synchronous, active-high.
- CB_Send_in  input  1  upstream request; a packet is valid while high.
- BR  input  1  branch select, taken from the packet (bit 18); 0 = branch a, 1 = branch b.
- CB_Ack_in_a  input  1  acknowledge from the branch-a receiver.
- CB_Ack_in_b  input  1  acknowledge from the branch-b receiver.
- CB_Ack_out  output  1  acknowledge to upstream.
- CB_Send_out_a  output  1  request to the branch-a receiver.
- CB_Send_out_b  output  1  request to the branch-b receiver.
- CB_CP  output  1  one-cycle capture pulse for the stage's data and flag latches.

Behaviour:
- All outputs are registered. Reset (MR=1 at a rising edge) forces all outputs to 0 on that edge.
- After reset: stage EMPTY, delay counter 0, branch select 0.
- MR overrides every other input, including mid-operation; any in-flight token is discarded.

Input side (4-phase handshake):
- Accept condition: stage EMPTY, CB_Ack_out=0, CB_Send_in=1 at edge k.
- At edge k:
  - CB_CP=1 for exactly one cycle; it returns to 0 at edge k+1.
  - CB_Ack_out goes to 1.
  - BR is sampled into an internal select register.
  - The delay counter loads DELAY.
  - State becomes FULL.
- CB_Ack_out stays 1 until CB_Send_in is sampled 0, then drops to 0 at that same edge.
- BR and CB_Send_in are ignored while a token is held; BR changes after edge k do not affect routing.

Output side (4-phase handshake):
- The selected output rises at edge k+DELAY. If DELAY=0, it rises at edge k, together with CB_CP.
- While FULL with a nonzero counter, the counter decrements by 1 per edge.
- The selected Send_out stays 1 until its own Ack_in is sampled 1; it drops to 0 at that edge and the state becomes DRAIN.
- In DRAIN, the stage waits for that Ack_in to be sampled 0, then becomes EMPTY at that edge.
- The non-selected branch's Send_out stays 0 throughout; its Ack_in is ignored in all states.
- An Ack_in that is high before the corresponding Send_out rises has no effect until Send_out=1 is registered.

Throughput and corner cases:
- A new token is accepted only from EMPTY with CB_Ack_out=0. If upstream holds CB_Send_in=1 continuously, CB_Ack_out stays 1, so no re-acceptance occurs.
- At most one of CB_Send_out_a and CB_Send_out_b is 1 at any time.
- CB_CP pulses exactly once per accepted token.
- Simultaneous Ack_in rise and counter expiry: Send_out is asserted first, then ack handling proceeds on the next edge.

Test Plan:
- Reset: assert MR for 2 cycles with CB_Send_in=1 -> all outputs 0 during reset; one cycle after MR falls, CB_CP=1 and CB_Ack_out=1.
- Branch a, DELAY=1: CB_Send_in=1, BR=0 at edge 0 -> CB_CP=1 only in cycle 0–1, CB_Ack_out=1 from edge 0, CB_Send_out_a=1 from edge 1, CB_Send_out_b stays 0. Drop CB_Send_in -> CB_Ack_out=0. Ack_in_a=1 -> Send_out_a=0. Ack_in_a=0 -> stage EMPTY.
- Branch b with BR flipping: BR=1 at accept, BR=0 one cycle later -> only CB_Send_out_b asserts; spurious CB_Ack_in_a pulses are ignored.
- Back-to-back tokens: hold CB_Send_in=1 for two full handshakes -> exactly two CB_CP pulses; the second accept occurs only after the first token drains and CB_Ack_out returned to 0.
- DELAY=0 and DELAY=3: Send_out rises at the same edge as CB_CP, and 3 edges after CB_CP, respectively.
- Mid-operation reset: MR=1 while CB_Send_out_b=1 -> all outputs 0 at the next edge; the pending ack is ignored; a fresh token is accepted afterwards.
